// File: rtl/axi_write_master_if.sv
// axi_write_master_if: AXI4 write-address, write-data and write-response channel bundle
interface axi_write_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) ();
  logic [ID_W-1:0]     M_AXI_AWID;
  logic [ADDR_W-1:0]   M_AXI_AWADDR;
  logic [7:0]          M_AXI_AWLEN;
  logic [2:0]          M_AXI_AWSIZE;
  logic [1:0]          M_AXI_AWBURST;
  logic                M_AXI_AWVALID;
  logic                M_AXI_AWREADY;
  logic [DATA_W-1:0]   M_AXI_WDATA;
  logic [DATA_W/8-1:0] M_AXI_WSTRB;
  logic                M_AXI_WLAST;
  logic                M_AXI_WVALID;
  logic                M_AXI_WREADY;
  logic [1:0]          M_AXI_BRESP;
  logic                M_AXI_BVALID;
  logic                M_AXI_BREADY;
  modport master (
    output M_AXI_AWID, M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWVALID,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID, M_AXI_BREADY,
    input  M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID
  );
  modport slave (
    input  M_AXI_AWID, M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWVALID,
    input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID, M_AXI_BREADY,
    output M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID
  );
endinterface

// File: rtl/axi_write_master.sv
// axi_write_master: issues one AXI4 write burst per descriptor, draining a show-ahead FIFO
module axi_write_master #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ID_WIDTH   = 4
) (
  input  logic                          AXI_aclk,
  input  logic                          AXI_aresetn,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] dst_addr,
  input  logic [1:0]                    burst_type,
  input  logic [2:0]                    burst_size,
  input  logic [8:0]                    beats,
  input  logic                          start_write,
  output logic                          write_transaction_completed,
  output logic                          write_resp_error,
  output logic                          busy,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] fifo_rdata,
  input  logic                          fifo_empty,
  output logic                          fifo_rd_en,
  axi_write_master_if.master            m_axi
);
  typedef enum logic [2:0] {IDLE, ADDR, DATA, RESP, DONE} state_e;
  state_e                        state_q, state_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]                    burst_q, burst_d;
  logic [2:0]                    size_q, size_d;
  logic [7:0]                    len_q, len_d;
  logic [8:0]                    rem_q, rem_d;
  logic                          err_q, err_d;
  logic                          legal, w_hs;
  assign legal = (beats != 9'd0) && (beats <= 9'd256);
  assign w_hs  = m_axi.M_AXI_WVALID && m_axi.M_AXI_WREADY;
  always_ff @(posedge AXI_aclk or negedge AXI_aresetn) begin
    if (!AXI_aresetn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      burst_q <= '0;
      size_q  <= '0;
      len_q   <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      burst_q <= burst_d;
      size_q  <= size_d;
      len_q   <= len_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
    end
  end
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    burst_d = burst_q;
    size_d  = size_q;
    len_d   = len_q;
    rem_d   = rem_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (start_write) begin
        state_d = legal ? ADDR : DONE;
        err_d   = !legal;
        if (legal) begin
          addr_d  = dst_addr;
          burst_d = burst_type;
          size_d  = burst_size;
          len_d   = 8'(beats - 9'd1);
          rem_d   = beats;
        end
      end
      ADDR: state_d = m_axi.M_AXI_AWREADY ? DATA : ADDR;
      DATA: if (w_hs) begin
        rem_d   = (rem_q != 9'd0) ? rem_q - 9'd1 : 9'd0;
        state_d = (rem_q == 9'd1) ? RESP : DATA;
      end
      RESP: if (m_axi.M_AXI_BVALID) begin
        err_d   = m_axi.M_AXI_BRESP != 2'b00;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  assign m_axi.M_AXI_AWID    = {C_M_AXI_ID_WIDTH{1'b0}};
  assign m_axi.M_AXI_AWADDR  = addr_q;
  assign m_axi.M_AXI_AWLEN   = len_q;
  assign m_axi.M_AXI_AWSIZE  = size_q;
  assign m_axi.M_AXI_AWBURST = burst_q;
  assign m_axi.M_AXI_AWVALID = state_q == ADDR;
  // data path is gated outside DATA so the bus reads all-zero when idle or in reset
  assign m_axi.M_AXI_WVALID  = (state_q == DATA) && !fifo_empty;
  assign m_axi.M_AXI_WDATA   = (state_q == DATA) ? fifo_rdata : '0;
  assign m_axi.M_AXI_WSTRB   = {(C_M_AXI_DATA_WIDTH/8){state_q == DATA}};
  assign m_axi.M_AXI_WLAST   = (state_q == DATA) && (rem_q == 9'd1);
  assign m_axi.M_AXI_BREADY  = state_q == RESP;
  assign fifo_rd_en                  = w_hs;
  assign write_transaction_completed = state_q == DONE;
  assign write_resp_error            = (state_q == DONE) && err_q;
  assign busy                        = state_q != IDLE;
endmodule
